// File: rtl/program_counter.sv
// rtl/program_counter.sv - free-running fetch-stage program counter (optional wrap flag: PC_WRAP_DETECT_EN)
module program_counter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] STEP         = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        pc_wrap
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

`ifdef PC_WRAP_DETECT_EN
    logic        carry_d;
    logic        wrap_q;

    // Next address with the carry kept so a wrap past the top of memory can be flagged.
    always_comb begin
        {carry_d, pc_d} = {1'b0, pc_q} + {1'b0, STEP};
    end

    // Wrap flag is high exactly in the cycle pc shows the wrapped address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= carry_d;
        end
    end

    assign pc_wrap = wrap_q;
`else
    // Next address, carry discarded; wrap is silent in this build.
    always_comb begin
        pc_d = pc_q + STEP;
    end

    assign pc_wrap = 1'b0;
`endif

    // Advance one step every cycle; reset forces the boot address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - table, directed and randomized checks of program_counter
module tb_program_counter;

    localparam int NI = 3;
    localparam longint MOD = 64'h1_0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_o   [NI];
    logic [31:0] pcn_o  [NI];
    logic        wrap_o [NI];

    longint      rv     [NI];
    longint      m_pc   [NI];
    logic        m_wrap [NI];

    int n_cmp;
    int n_bad;

    program_counter u_def (
        .clk(clk), .rst(rst), .pc(pc_o[0]), .pc_next(pcn_o[0]), .pc_wrap(wrap_o[0])
    );

    program_counter #(.RESET_VECTOR(32'h0000_1000), .STEP(32'd4)) u_cust (
        .clk(clk), .rst(rst), .pc(pc_o[1]), .pc_next(pcn_o[1]), .pc_wrap(wrap_o[1])
    );

    program_counter #(.RESET_VECTOR(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .pc(pc_o[2]), .pc_next(pcn_o[2]), .pc_wrap(wrap_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc_def;
        logic [31:0] pc_cust;
        logic [31:0] pc_wr;
        logic        wrap;
    } vec_t;

    vec_t vecs [12];

`ifdef PC_WRAP_DETECT_EN
    localparam logic WRAP_ON = 1'b1;
`else
    localparam logic WRAP_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive rst for one edge, advance the reference model, sample at the following falling edge.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                m_pc[k]   = rv[k];
                m_wrap[k] = 1'b0;
            end else begin
                m_wrap[k] = WRAP_ON && ((m_pc[k] + 4) >= MOD);
                m_pc[k]   = (m_pc[k] + 4) % MOD;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk({tag, "_pc"},      pc_o[k],        32'(m_pc[k]));
            chk({tag, "_pc_next"}, pcn_o[k],       32'((m_pc[k] + 4) % MOD));
            chk({tag, "_wrap"},    {31'b0, wrap_o[k]}, {31'b0, m_wrap[k]});
        end
    endtask

    initial begin
        logic found;
        n_cmp = 0;
        n_bad = 0;
        rv[0] = 64'h0;
        rv[1] = 64'h1000;
        rv[2] = 64'hFFFF_FFF8;
        for (int k = 0; k < NI; k++) begin
            m_pc[k]   = 0;
            m_wrap[k] = 1'b0;
        end
        rst = 1'b1;

        vecs[0]  = '{1'b1, 32'h00, 32'h1000, 32'hFFFF_FFF8, 1'b0};
        vecs[1]  = '{1'b1, 32'h00, 32'h1000, 32'hFFFF_FFF8, 1'b0};
        vecs[2]  = '{1'b0, 32'h04, 32'h1004, 32'hFFFF_FFFC, 1'b0};
        vecs[3]  = '{1'b0, 32'h08, 32'h1008, 32'h0000_0000, WRAP_ON};
        vecs[4]  = '{1'b0, 32'h0C, 32'h100C, 32'h0000_0004, 1'b0};
        vecs[5]  = '{1'b0, 32'h10, 32'h1010, 32'h0000_0008, 1'b0};
        vecs[6]  = '{1'b0, 32'h14, 32'h1014, 32'h0000_000C, 1'b0};
        vecs[7]  = '{1'b0, 32'h18, 32'h1018, 32'h0000_0010, 1'b0};
        vecs[8]  = '{1'b0, 32'h1C, 32'h101C, 32'h0000_0014, 1'b0};
        vecs[9]  = '{1'b0, 32'h20, 32'h1020, 32'h0000_0018, 1'b0};
        vecs[10] = '{1'b0, 32'h24, 32'h1024, 32'h0000_001C, 1'b0};
        vecs[11] = '{1'b0, 32'h28, 32'h1028, 32'h0000_0020, 1'b0};

        // Reset-then-count run with fixed expectations.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst);
            chk("tbl_pc_def",   pc_o[0],  vecs[i].pc_def);
            chk("tbl_next_def", pcn_o[0], vecs[i].pc_def + 32'd4);
            chk("tbl_wrap_def", {31'b0, wrap_o[0]}, 32'd0);
            chk("tbl_pc_cust",  pc_o[1],  vecs[i].pc_cust);
            chk("tbl_pc_wr",    pc_o[2],  vecs[i].pc_wr);
            chk("tbl_next_wr",  pcn_o[2], vecs[i].pc_wr + 32'd4);
            chk("tbl_wrap_wr",  {31'b0, wrap_o[2]}, {31'b0, vecs[i].wrap});
        end

        // Mid-run reset: count up to 0x1C, then pulse reset for one edge.
        step(1'b1);
        chk_model("mid_rst0");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0);
            chk_model("mid_cnt");
            if (pc_o[0] == 32'h1C) found = 1'b1;
        end
        chk("mid_reach_1c", {31'b0, found}, 32'd1);
        step(1'b1);
        chk("mid_pulse_pc", pc_o[0], 32'h0);
        chk_model("mid_pulse");
        step(1'b0);
        chk("mid_after_pc", pc_o[0], 32'h4);
        chk_model("mid_after");

        // Reset held over several edges.
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk_model("hold_rst");
        end

        // Randomized reset pattern against the reference model.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7) == 0);
            chk_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
